// File: rtl/alu_share_arb.sv
// alu_share_arb: two-requester round-robin arbiter and sequencer for one
// shared combinational ALU. The winning operation is registered into an
// issue stage (S1) that drives the ALU ports. The ALU result is captured
// into a one-entry response buffer owned by the requester that issued it.
module alu_share_arb #(
    parameter int DATA_W = 32,
    parameter int CONF_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CONF_W-1:0] req0_conf,
    input  logic              req0_sign,
    input  logic [DATA_W-1:0] req0_in1,
    input  logic [DATA_W-1:0] req0_in2,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CONF_W-1:0] req1_conf,
    input  logic              req1_sign,
    input  logic [DATA_W-1:0] req1_in1,
    input  logic [DATA_W-1:0] req1_in2,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,

    output logic [CONF_W-1:0] alu_conf,
    output logic              alu_sign,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_result
);

    // Issue stage registers; they drive the ALU directly.
    logic              s1_valid_q;
    logic              s1_src_q;
    logic [CONF_W-1:0] s1_conf_q;
    logic              s1_sign_q;
    logic [DATA_W-1:0] s1_in1_q;
    logic [DATA_W-1:0] s1_in2_q;

    // Round-robin history: the requester granted by the last accepted handshake.
    logic              last_grant_q;

    // Response buffers, one entry per requester.
    logic              rsp0_valid_q;
    logic [DATA_W-1:0] rsp0_data_q;
    logic              rsp1_valid_q;
    logic [DATA_W-1:0] rsp1_data_q;

    // Combinational control.
    logic              s1_adv_s;
    logic              s1_free_s;
    logic              grant_s;
    logic              accept_s;
    logic              adv_to_0_s;
    logic              adv_to_1_s;
    logic [CONF_W-1:0] sel_conf_s;
    logic              sel_sign_s;
    logic [DATA_W-1:0] sel_in1_s;
    logic [DATA_W-1:0] sel_in2_s;

    // A buffer can take a new result when it is empty or being drained now.
    function automatic logic buf_open(input logic valid, input logic ready);
        return (~valid) | ready;
    endfunction

    // Round-robin pick: on contention the requester not granted last time wins.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
        logic pick;
        if (v0 && v1) begin
            pick = ~last;
        end else if (v1) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

    // Advance/accept conditions, arbitration and selection of the winner's fields.
    always_comb begin
        s1_adv_s   = 1'b0;
        s1_free_s  = 1'b0;
        grant_s    = 1'b0;
        sel_conf_s = '0;
        sel_sign_s = 1'b0;
        sel_in1_s  = '0;
        sel_in2_s  = '0;

        // S1 can only retire into its own requester's buffer; the other
        // buffer never unblocks it (head-of-line blocking is accepted).
        if (s1_src_q) begin
            s1_adv_s = s1_valid_q & buf_open(rsp1_valid_q, rsp1_ready);
        end else begin
            s1_adv_s = s1_valid_q & buf_open(rsp0_valid_q, rsp0_ready);
        end
        s1_free_s = (~s1_valid_q) | s1_adv_s;

        grant_s = rr_pick(req0_valid, req1_valid, last_grant_q);

        if (grant_s) begin
            sel_conf_s = req1_conf;
            sel_sign_s = req1_sign;
            sel_in1_s  = req1_in1;
            sel_in2_s  = req1_in2;
        end else begin
            sel_conf_s = req0_conf;
            sel_sign_s = req0_sign;
            sel_in1_s  = req0_in1;
            sel_in2_s  = req0_in2;
        end
    end

    // Ready is gated by the requester's own valid so it marks a real handshake.
    assign req0_ready = s1_free_s & ~grant_s & req0_valid;
    assign req1_ready = s1_free_s &  grant_s & req1_valid;
    assign accept_s   = req0_ready | req1_ready;
    assign adv_to_0_s = s1_adv_s & ~s1_src_q;
    assign adv_to_1_s = s1_adv_s &  s1_src_q;

    // Issue stage: load on acceptance, retire on advance, otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_src_q   <= 1'b0;
            s1_conf_q  <= '0;
            s1_sign_q  <= 1'b0;
            s1_in1_q   <= '0;
            s1_in2_q   <= '0;
        end else if (accept_s) begin
            s1_valid_q <= 1'b1;
            s1_src_q   <= grant_s;
            s1_conf_q  <= sel_conf_s;
            s1_sign_q  <= sel_sign_s;
            s1_in1_q   <= sel_in1_s;
            s1_in2_q   <= sel_in2_s;
        end else if (s1_adv_s) begin
            // Operand fields keep their last value so the ALU inputs stay quiet.
            s1_valid_q <= 1'b0;
        end
    end

    // Round-robin history moves only on an accepted handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else if (accept_s) begin
            last_grant_q <= grant_s;
        end
    end

    // Requester 0 response buffer: a refill takes priority over a pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp0_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
        end else if (adv_to_0_s) begin
            rsp0_valid_q <= 1'b1;
            rsp0_data_q  <= alu_result;
        end else if (rsp0_valid_q && rsp0_ready) begin
            rsp0_valid_q <= 1'b0;
        end
    end

    // Requester 1 response buffer: a refill takes priority over a pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp1_valid_q <= 1'b0;
            rsp1_data_q  <= '0;
        end else if (adv_to_1_s) begin
            rsp1_valid_q <= 1'b1;
            rsp1_data_q  <= alu_result;
        end else if (rsp1_valid_q && rsp1_ready) begin
            rsp1_valid_q <= 1'b0;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_data  = rsp1_data_q;

    assign alu_conf   = s1_conf_q;
    assign alu_sign   = s1_sign_q;
    assign alu_in1    = s1_in1_q;
    assign alu_in2    = s1_in2_q;

endmodule
